baseball_game: RTL

BASEBALL_GAME -- requirements
Module: baseball_game

---
 rtl/baseball_pkg.sv | 46 ++++
 rtl/base_advance.sv | 53 +++++
 rtl/baseball_game.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/baseball_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : baseball_pkg
// Purpose  : Shared play codes, base-bit indices, inning ceiling and the
//            game-state encoding for the baseball scorekeeper.
// Revision : 1.0  initial release
// ============================================================================
package baseball_pkg;

  // Play codes carried on play_code
  localparam logic [2:0] c_play_nop      = 3'd0;
  localparam logic [2:0] c_play_single   = 3'd1;
  localparam logic [2:0] c_play_double   = 3'd2;
  localparam logic [2:0] c_play_triple   = 3'd3;
  localparam logic [2:0] c_play_home_run = 3'd4;
  localparam logic [2:0] c_play_out      = 3'd5;
  localparam logic [2:0] c_play_walk     = 3'd6;
  localparam logic [2:0] c_play_nop_hi   = 3'd7;

  // Bit positions inside the bases vector
  localparam int unsigned c_base_first  = 0;
  localparam int unsigned c_base_second = 1;
  localparam int unsigned c_base_third  = 2;

  // Hard ceiling on innings: a tie at the end of this inning ends the game
  localparam int unsigned c_max_inning = 15;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_CHANGE = 2'd1,
    ST_OVER   = 2'd2
  } game_state_e;

  // Number of set bits: each set bit is a runner (or batter) who crossed home
  function automatic logic [2:0] count_runs(input logic [4:0] crossed);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, crossed[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/base_advance.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : base_advance
// Purpose  : Combinational runner advancement for hits and walks; reports
//            the new base occupancy and the runs scored by the play.
// Revision : 1.0  initial release
// ============================================================================
module base_advance
  import baseball_pkg::*;
(
  input  logic [2:0] bases,
  input  logic [2:0] play_code,
  output logic [2:0] new_bases,
  output logic [2:0] runs
);

  // Bit i of w_adv is base i+1 after the hit; bits 3 and up have crossed home.
  logic [7:0] w_adv;
  logic [2:0] w_batter_idx;

  // Shift every runner by the hit length and drop the batter on base k
  always_comb begin
    w_batter_idx = play_code - 3'd1;
    w_adv        = ({5'b00000, bases} << play_code) | (8'd1 << w_batter_idx);
  end

  // Select the outcome for the offered play code
  always_comb begin
    new_bases = bases;
    runs      = '0;
    case (play_code)
      c_play_single, c_play_double, c_play_triple, c_play_home_run: begin
        new_bases = w_adv[2:0];
        runs      = count_runs(w_adv[7:3]);
      end
      c_play_walk: begin
        // Forced advance: a runner moves only if every base behind him is full
        new_bases[c_base_first]  = 1'b1;
        new_bases[c_base_second] = bases[c_base_second] | bases[c_base_first];
        new_bases[c_base_third]  = bases[c_base_third]
                                 | (bases[c_base_second] & bases[c_base_first]);
        runs                     = {2'b00, &bases};
      end
      default: begin
        new_bases = bases;
        runs      = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/baseball_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : baseball_game
// Purpose  : Baseball scorekeeper: accepts plays, tracks bases, outs,
//            inning, half and scores, and decides when the game ends.
// Revision : 1.0  initial release
// ============================================================================
module baseball_game
  import baseball_pkg::*;
#(
  parameter int OUTS_PER_HALF = 3,
  parameter int INNINGS       = 9,
  parameter int SCORE_W       = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               play_valid,
  input  logic [2:0]         play_code,
  output logic               play_ready,
  output logic [2:0]         bases,
  output logic [2:0]         outs,
  output logic [3:0]         inning,
  output logic               half,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [2:0]         runs_pulse,
  output logic               change_pulse,
  output logic               game_over
);

  game_state_e r_state;

  logic [2:0]         w_new_bases;
  logic [2:0]         w_runs;
  logic [SCORE_W-1:0] w_bat_score;
  logic [SCORE_W:0]   w_bat_sum;
  logic [SCORE_W-1:0] w_bat_sat;
  logic [SCORE_W-1:0] w_score0_n;
  logic [SCORE_W-1:0] w_score1_n;
  logic [2:0]         w_outs_inc;
  logic               w_half_end;
  logic               w_late;
  logic               w_walk_off;
  logic               w_final_half;

  base_advance u_base_advance (
    .bases     (bases),
    .play_code (play_code),
    .new_bases (w_new_bases),
    .runs      (w_runs)
  );

  // Resulting scores and game-end conditions for the offered play
  always_comb begin
    w_bat_score = half ? score1 : score0;
    w_bat_sum   = {1'b0, w_bat_score} + (SCORE_W+1)'(w_runs);
    w_bat_sat   = w_bat_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_bat_sum[SCORE_W-1:0];
    w_score0_n  = half ? score0 : w_bat_sat;
    w_score1_n  = half ? w_bat_sat : score1;
    w_outs_inc  = outs + 3'd1;
    w_half_end  = (play_code == c_play_out) && (w_outs_inc == 3'(OUTS_PER_HALF));
    w_late      = (inning >= 4'(INNINGS));
    // Home team takes the lead in a deciding inning: game ends on the spot
    w_walk_off  = half && w_late && (w_score1_n > w_score0_n);
    if (!half) begin
      // Home team already ahead after the top of a deciding inning
      w_final_half = w_late && (score1 > score0);
    end else begin
      // Visitors ahead, or the last permitted inning ended (tie allowed)
      w_final_half = w_late && ((score0 > score1) || (inning == 4'(c_max_inning)));
    end
  end

  // Game-state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_PLAY;
      play_ready   <= 1'b1;
      bases        <= '0;
      outs         <= '0;
      inning       <= 4'd1;
      half         <= 1'b0;
      score0       <= '0;
      score1       <= '0;
      runs_pulse   <= '0;
      change_pulse <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      runs_pulse   <= '0;
      change_pulse <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (play_valid) begin
            runs_pulse <= w_runs;
            bases      <= w_new_bases;
            score0     <= w_score0_n;
            score1     <= w_score1_n;
            if (w_walk_off) begin
              r_state    <= ST_OVER;
              game_over  <= 1'b1;
              play_ready <= 1'b0;
            end else if (w_half_end && w_final_half) begin
              // Deciding out: freeze the state as it stands, no change pulse
              outs       <= w_outs_inc;
              r_state    <= ST_OVER;
              game_over  <= 1'b1;
              play_ready <= 1'b0;
            end else if (w_half_end) begin
              bases        <= '0;
              outs         <= '0;
              change_pulse <= 1'b1;
              play_ready   <= 1'b0;
              r_state      <= ST_CHANGE;
              if (half) begin
                half   <= 1'b0;
                inning <= inning + 4'd1;
              end else begin
                half <= 1'b1;
              end
            end else if (play_code == c_play_out) begin
              outs <= w_outs_inc;
            end
          end
        end
        ST_CHANGE: begin
          r_state    <= ST_PLAY;
          play_ready <= 1'b1;
        end
        ST_OVER: begin
          play_ready <= 1'b0;
        end
        default: begin
          r_state    <= ST_PLAY;
          play_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
